alu_muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the ALU input multiplexer. It consumes the selected operands `alu_data_1` and `alu_data_2` in parallel with the single-cycle ALU. It runs a multi-cycle shift-add multiply or restoring divide and returns one result word with a busy/done handshake. The execute stage stalls on `busy` and writes `result` back when `done` pulses.

---
 rtl/muldiv_pkg.sv | 49 ++++
 rtl/muldiv_sign_fix.sv | 30 +++
 rtl/alu_muldiv_unit.sv | 236 +++++++++++++++++++++++
 tb/tb_alu_muldiv_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative RV32M multiply/divide unit.
//   - funct3 encodings of the eight RV32M operations
//   - FSM state enum
//   - iteration count and signed-overflow dividend constant
//   - operand signedness helpers derived from funct3
package muldiv_pkg;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  localparam int          ITER_COUNT   = 32;
  localparam logic [31:0] OVF_DIVIDEND = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Operand 1 is signed for MUL, MULH, MULHSU, DIV and REM.
  function automatic logic op1_signed(input logic [2:0] f);
    logic s;
    case (f)
      FUNCT3_MUL, FUNCT3_MULH, FUNCT3_MULHSU,
      FUNCT3_DIV, FUNCT3_REM:                 s = 1'b1;
      default:                                s = 1'b0;
    endcase
    return s;
  endfunction

  // Operand 2 is signed for MUL, MULH, DIV and REM (not MULHSU).
  function automatic logic op2_signed(input logic [2:0] f);
    logic s;
    case (f)
      FUNCT3_MUL, FUNCT3_MULH,
      FUNCT3_DIV, FUNCT3_REM:  s = 1'b1;
      default:                 s = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: combinational conditional two's-complement negate.
//   Used as absolute-value logic (is_signed=1, force_neg=0: negates when the
//   MSB is set) and as the final sign correction (is_signed=0, force_neg=flag).
// Ports:
//   value     in  W  input word
//   is_signed in  1  treat value as signed; negative values are negated
//   force_neg in  1  negate unconditionally
//   fixed     out W  corrected word
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         is_signed,
  input  logic         force_neg,
  output logic [W-1:0] fixed
);

  logic do_neg_s;

  // Negate either on request or when a signed value is negative.
  always_comb begin
    do_neg_s = force_neg | (is_signed & value[W-1]);
    if (do_neg_s) begin
      fixed = (~value) + W'(1'b1);
    end else begin
      fixed = value;
    end
  end

endmodule

// File: rtl/alu_muldiv_unit.sv
// alu_muldiv_unit: iterative RV32M multiply/divide unit (execute stage).
//   Shift-add multiply and restoring divide, one step per cycle, followed by
//   a sign-fix cycle. Divide-by-zero and signed overflow finish immediately.
// Ports:
//   clk        in  1     clock
//   rst_n      in  1     asynchronous active-low reset
//   start      in  1     request strobe, accepted only in IDLE
//   kill       in  1     flush; aborts any operation, no done
//   funct3     in  3     RV32M operation select
//   alu_data_1 in  XLEN  rs1 / multiplicand / dividend
//   alu_data_2 in  XLEN  rs2 / multiplier / divisor
//   busy       out 1     operation in progress (CALC or FIX)
//   done       out 1     one-cycle completion pulse
//   result     out XLEN  registered result, held until next request
module alu_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] alu_data_1,
  input  logic [XLEN-1:0] alu_data_2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int              CNT_W    = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  state_t              state_r, state_next_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [2:0]          f3_r;
  logic [2*XLEN-1:0]   acc_r;        // {hi, lo}: product, or {remainder, quotient}
  logic [XLEN-1:0]     op_r;         // multiplicand or divisor magnitude
  logic                res_neg_r;    // negate product / quotient in FIX
  logic                rem_neg_r;    // negate remainder in FIX
  logic                busy_r, done_r;
  logic [XLEN-1:0]     result_r;

  logic                a_signed_s, b_signed_s, a_neg_s, b_neg_s;
  logic [XLEN-1:0]     abs_a_s, abs_b_s;
  logic                div_zero_s, ovf_s, special_s, accept_s;
  logic [XLEN-1:0]     special_val_s;
  logic [2*XLEN-1:0]   step_s;
  logic [XLEN:0]       sum_s, shifted_s, diff_s;
  logic [2*XLEN-1:0]   prod_fixed_s;
  logic [XLEN-1:0]     quo_fixed_s, rem_fixed_s, fix_word_s;
  logic                busy_next_s, done_next_s;

  // Operand magnitudes for the iteration.
  muldiv_sign_fix #(.W(XLEN)) u_abs_a (
    .value     (alu_data_1),
    .is_signed (a_signed_s),
    .force_neg (1'b0),
    .fixed     (abs_a_s)
  );

  muldiv_sign_fix #(.W(XLEN)) u_abs_b (
    .value     (alu_data_2),
    .is_signed (b_signed_s),
    .force_neg (1'b0),
    .fixed     (abs_b_s)
  );

  // Sign corrections applied in FIX.
  muldiv_sign_fix #(.W(2*XLEN)) u_fix_prod (
    .value     (acc_r),
    .is_signed (1'b0),
    .force_neg (res_neg_r),
    .fixed     (prod_fixed_s)
  );

  muldiv_sign_fix #(.W(XLEN)) u_fix_quo (
    .value     (acc_r[XLEN-1:0]),
    .is_signed (1'b0),
    .force_neg (res_neg_r),
    .fixed     (quo_fixed_s)
  );

  muldiv_sign_fix #(.W(XLEN)) u_fix_rem (
    .value     (acc_r[2*XLEN-1:XLEN]),
    .is_signed (1'b0),
    .force_neg (rem_neg_r),
    .fixed     (rem_fixed_s)
  );

  // Request decode: signedness, special cases and their immediate result.
  always_comb begin
    a_signed_s = op1_signed(funct3);
    b_signed_s = op2_signed(funct3);
    a_neg_s    = a_signed_s & alu_data_1[XLEN-1];
    b_neg_s    = b_signed_s & alu_data_2[XLEN-1];
    div_zero_s = funct3[2] && (alu_data_2 == {XLEN{1'b0}});
    ovf_s      = ((funct3 == FUNCT3_DIV) || (funct3 == FUNCT3_REM)) &&
                 (alu_data_1 == OVF_DIVIDEND) && (alu_data_2 == {XLEN{1'b1}});
    special_s  = div_zero_s | ovf_s;
    accept_s   = (state_r == IDLE) && start && !kill;
    // funct3[1] distinguishes REM/REMU from DIV/DIVU.
    if (div_zero_s) begin
      special_val_s = funct3[1] ? alu_data_1 : {XLEN{1'b1}};
    end else if (ovf_s) begin
      special_val_s = funct3[1] ? {XLEN{1'b0}} : OVF_DIVIDEND;
    end else begin
      special_val_s = {XLEN{1'b0}};
    end
  end

  // One multiply or restoring-divide step on the accumulator.
  always_comb begin
    sum_s     = {1'b0, acc_r[2*XLEN-1:XLEN]} +
                (acc_r[0] ? {1'b0, op_r} : {(XLEN+1){1'b0}});
    shifted_s = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
    diff_s    = shifted_s - {1'b0, op_r};
    if (f3_r[2]) begin
      // No borrow means the shifted remainder covers the divisor.
      if (!diff_s[XLEN]) begin
        step_s = {diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
      end else begin
        step_s = {shifted_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
      end
    end else begin
      step_s = {sum_s, acc_r[XLEN-1:1]};
    end
  end

  // Select the corrected result word for the latched operation.
  always_comb begin
    case (f3_r)
      FUNCT3_MUL:                             fix_word_s = prod_fixed_s[XLEN-1:0];
      FUNCT3_MULH, FUNCT3_MULHSU, FUNCT3_MULHU: fix_word_s = prod_fixed_s[2*XLEN-1:XLEN];
      FUNCT3_DIV, FUNCT3_DIVU:                fix_word_s = quo_fixed_s;
      FUNCT3_REM, FUNCT3_REMU:                fix_word_s = rem_fixed_s;
      default:                                fix_word_s = {XLEN{1'b0}};
    endcase
  end

  // Next-state and next-output logic; kill overrides every transition.
  always_comb begin
    state_next_s = state_r;
    if (kill) begin
      state_next_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_next_s = special_s ? DONE : CALC;
          end else begin
            state_next_s = IDLE;
          end
        end
        CALC: begin
          if (cnt_r == CNT_LAST) begin
            state_next_s = FIX;
          end else begin
            state_next_s = CALC;
          end
        end
        FIX:     state_next_s = DONE;
        DONE:    state_next_s = IDLE;
        default: state_next_s = IDLE;
      endcase
    end
    busy_next_s = (state_next_s == CALC) || (state_next_s == FIX);
    done_next_s = (state_next_s == DONE);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r     <= {CNT_W{1'b0}};
      f3_r      <= 3'b000;
      acc_r     <= {(2*XLEN){1'b0}};
      op_r      <= {XLEN{1'b0}};
      res_neg_r <= 1'b0;
      rem_neg_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      result_r  <= {XLEN{1'b0}};
    end else begin
      busy_r <= busy_next_s;
      done_r <= done_next_s;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            f3_r      <= funct3;
            cnt_r     <= {CNT_W{1'b0}};
            res_neg_r <= a_neg_s ^ b_neg_s;
            rem_neg_r <= a_neg_s;
            if (funct3[2]) begin
              acc_r <= {{XLEN{1'b0}}, abs_a_s};
              op_r  <= abs_b_s;
            end else begin
              acc_r <= {{XLEN{1'b0}}, abs_b_s};
              op_r  <= abs_a_s;
            end
            if (special_s) begin
              result_r <= special_val_s;
            end
          end
        end
        CALC: begin
          if (!kill) begin
            acc_r <= step_s;
            cnt_r <= cnt_r + CNT_W'(1'b1);
          end
        end
        FIX: begin
          if (!kill) begin
            result_r <= fix_word_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;

endmodule

// File: tb/tb_alu_muldiv_unit.sv
module tb_alu_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy, done;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  logic [31:0] last_res = 32'd0;

  always #5 clk = ~clk;

  alu_muldiv_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .kill       (kill),
    .funct3     (funct3),
    .alu_data_1 (a),
    .alu_data_2 (b),
    .busy       (busy),
    .done       (done),
    .result     (result)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Architectural RV32M result using 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, uy;
    logic [63:0] ux64, uy64, p;
    logic [31:0] r;
    bit          ovf;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    uy = longint'({32'd0, y});
    ux64 = {32'd0, x};
    uy64 = {32'd0, y};
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    r = 32'd0;
    case (f)
      FUNCT3_MUL:    begin p = 64'(sx * sy);     r = p[31:0];  end
      FUNCT3_MULH:   begin p = 64'(sx * sy);     r = p[63:32]; end
      FUNCT3_MULHSU: begin p = 64'(sx * uy);     r = p[63:32]; end
      FUNCT3_MULHU:  begin p = ux64 * uy64;      r = p[63:32]; end
      FUNCT3_DIV: begin
        if (y == 32'd0) r = 32'hFFFF_FFFF;
        else if (ovf)   r = 32'h8000_0000;
        else begin p = 64'(sx / sy); r = p[31:0]; end
      end
      FUNCT3_DIVU: r = (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
      FUNCT3_REM: begin
        if (y == 32'd0) r = x;
        else if (ovf)   r = 32'd0;
        else begin p = 64'(sx % sy); r = p[31:0]; end
      end
      FUNCT3_REMU: r = (y == 32'd0) ? x : x % y;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    return f[2] && ((y == 32'd0) ||
           (((f == FUNCT3_DIV) || (f == FUNCT3_REM)) && (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF)));
  endfunction

  // Observable-behaviour model: busy for 33 edges after acceptance, then a
  // one-cycle done; special cases finish at the accepting edge.
  logic        m_busy = 1'b0, m_done = 1'b0;
  logic [31:0] m_result = 32'd0, m_pend = 32'd0;
  int          m_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_result <= 32'd0; m_pend <= 32'd0; m_cnt <= 0;
    end else if (kill) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_cnt <= 0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_busy) begin
      if (m_cnt == 1) begin
        m_busy <= 1'b0; m_done <= 1'b1; m_result <= m_pend;
      end
      m_cnt <= m_cnt - 1;
    end else if (start) begin
      if (is_special(funct3, a, b)) begin
        m_done <= 1'b1; m_result <= ref_result(funct3, a, b);
      end else begin
        m_busy <= 1'b1; m_cnt <= 33; m_pend <= ref_result(funct3, a, b);
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc busy", {31'd0, busy}, {31'd0, m_busy});
      check("cyc done", {31'd0, done}, {31'd0, m_done});
      check("cyc result", result, m_result);
    end
  end

  // Issue one request, wait for done, check result and latency (edges from
  // the accepting edge to the done cycle). poke pulses start while busy.
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp, input int exp_edges,
                        input bit poke);
    int edges;
    bit got;
    @(posedge clk); #1;
    funct3 = f; a = x; b = y; start = 1'b1;
    edges = 0; got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk); #1;
      start = 1'b0; a = $urandom; b = $urandom; funct3 = 3'($urandom);
      edges++;
      if (poke && (edges == 5 || edges == 20)) begin
        start = 1'b1; funct3 = FUNCT3_DIV; a = 32'd9; b = 32'd0;
      end
      @(negedge clk);
      if (done) got = 1'b1;
    end
    check({name, " done seen"}, {31'd0, got}, 32'd1);
    check({name, " result"}, result, exp);
    check({name, " latency"}, 32'(edges), 32'(exp_edges));
    last_res = exp;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset result", result, 32'd0);
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_op("MUL 7*-3",        FUNCT3_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 1'b0);
    run_op("MULH min*min",    FUNCT3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 1'b0);
    run_op("MULHU max*max",   FUNCT3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 1'b0);
    run_op("MULHSU -1*max",   FUNCT3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 1'b0);
    run_op("MULH -1*7",       FUNCT3_MULH,   32'hFFFF_FFFF, 32'h0000_0007, 32'hFFFF_FFFF, 34, 1'b0);
    run_op("DIV -7/2",        FUNCT3_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34, 1'b0);
    run_op("REM -7/2",        FUNCT3_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34, 1'b0);
    run_op("DIV 7/-3",        FUNCT3_DIV,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 34, 1'b0);
    run_op("REM 7/-3",        FUNCT3_REM,    32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0001, 34, 1'b0);
    run_op("DIVU 100/7",      FUNCT3_DIVU,   32'd100,       32'd7,         32'd14,        34, 1'b0);
    run_op("REMU 100/7",      FUNCT3_REMU,   32'd100,       32'd7,         32'd2,         34, 1'b0);
    run_op("DIVU max/1",      FUNCT3_DIVU,   32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 34, 1'b0);
    run_op("DIV 5/0",         FUNCT3_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1,  1'b0);
    run_op("REM 5/0",         FUNCT3_REM,    32'd5,         32'd0,         32'd5,         1,  1'b0);
    run_op("DIV ovf",         FUNCT3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  1'b0);
    run_op("REM ovf",         FUNCT3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1,  1'b0);
    run_op("MULHU pokes",     FUNCT3_MULHU,  32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 34, 1'b1);

    // Kill during the 10th CALC cycle.
    begin
      bit seen;
      @(posedge clk); #1;
      funct3 = FUNCT3_MUL; a = 32'd3; b = 32'd5; start = 1'b1;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        start = 1'b0;
      end
      kill = 1'b1;
      @(posedge clk); #1;
      kill = 1'b0;
      @(negedge clk);
      check("kill busy low", {31'd0, busy}, 32'd0);
      seen = 1'b0;
      repeat (40) begin
        @(negedge clk);
        if (done) seen = 1'b1;
      end
      check("kill no done", {31'd0, seen}, 32'd0);
      check("kill result held", result, last_res);
    end

    // Reset asserted mid-CALC.
    begin
      bit seen;
      @(posedge clk); #1;
      funct3 = FUNCT3_DIVU; a = 32'd1000; b = 32'd3; start = 1'b1;
      for (int i = 0; i < 6; i++) begin
        @(posedge clk); #1;
        start = 1'b0;
      end
      #1 rst_n = 1'b0;
      #1;
      check("rst busy", {31'd0, busy}, 32'd0);
      check("rst done", {31'd0, done}, 32'd0);
      check("rst result", result, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      seen = 1'b0;
      repeat (40) begin
        @(negedge clk);
        if (done) seen = 1'b1;
      end
      check("rst no done", {31'd0, seen}, 32'd0);
    end

    run_op("MUL after rst",   FUNCT3_MUL,    32'd6,         32'd7,         32'd42,        34, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
